pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Parametrised pipeline control unit for the in-order CPU core, replacing the single-source stall decoder. It merges several per-stage stall requests into one stall vector and sequences a multi-cycle flush with a redirect PC on exception/redirect events. It also keeps a saturating stall-cycle counter and a sticky stall watchdog. The block sits beside the pipeline registers and drives every stage's stall/flush inputs.

## Interface
- `STAGES`, 6: stall vector width; bit 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB.
- `NREQ`, 3: number of stall request sources.
- `REQ_STAGE`, {8'd4, 8'd3, 8'd2}: packed NREQ×8; source i sits at stage index `REQ_STAGE[8*i+:8]`; each value must be < STAGES.
- `FLUSH_CYCLES`, 1: cycles flush stays asserted per event; must be ≥ 1.
- `MAX_STALL`, 64: consecutive-stall limit before the watchdog fires; must be ≥ 1.
- `CNT_W`, 32: stall-cycle counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset (0 = reset).
- `stall_req` in NREQ: bit i = source i requests a stall (the `Stop` level is 1).
- `excp_valid` in 1: exception/redirect event this cycle.
- `excp_pc` in 32: redirect target, sampled when `excp_valid` = 1.
- `stall` out STAGES: per-stage hold.
- `flush` out 1: clear all pipeline registers.
- `new_pc` out 32: redirect PC, valid while `flush` = 1.
- `stall_cycles` out CNT_W: saturating count of cycles with `stall` ≠ 0.
- `stall_timeout` out 1: sticky watchdog flag.

## Operation
- Stall merge (combinational): source i active at stage k sets `stall[k:0]`. The output is the OR over all active sources. Example: ID request gives 000111.
- States: RUN and FLUSH.
  - RUN → FLUSH when `excp_valid` = 1. On that edge, latch `excp_pc` into `new_pc` and load `flush_cnt = FLUSH_CYCLES-1`.
  - In FLUSH: `flush` = 1.
    - If `flush_cnt` = 0, return to RUN.
    - Otherwise decrement `flush_cnt`.
  - `excp_valid` during FLUSH restarts the sequence: reload the count and relatch `new_pc` (latest event wins).
- Priority: `stall` is forced to 0 in any cycle where the state is FLUSH or `excp_valid` = 1. Flush preempts stall.
- Watchdog:
  - `run_len` (width clog2(MAX_STALL+1)) increments each cycle `stall` ≠ 0 and clears when `stall` = 0. It saturates at MAX_STALL.
  - `stall_timeout` sets when `run_len` = MAX_STALL and `stall` ≠ 0. It clears only on reset.
- `stall_cycles` increments each cycle `stall` ≠ 0 and holds at 2^CNT_W−1.

## Timing
- Reset values: state RUN, `stall` = 0, `flush` = 0, `new_pc` = 0, `stall_cycles` = 0, `stall_timeout` = 0, `run_len` = 0, `flush_cnt` = 0.
- Stall has zero latency: a request in cycle t drives `stall` in cycle t.
- Flush timing: `excp_valid` in cycle t gives `flush` = 1 in cycles t+1 … t+FLUSH_CYCLES, with `new_pc` = `excp_pc`(t).
- After flush: requests are honoured again from cycle t+FLUSH_CYCLES+1.
- Counters update on the edge ending the stalled cycle.
- Timeout latency: with MAX_STALL = M, continuous stall from cycle t gives `stall_timeout` = 1 from cycle t+M+1.
- Reset mid-FLUSH: `flush` drops immediately (asynchronous) and the state returns to RUN.

## Structure
- `lib/defines.vh` holds the shared constants:
  - `StallBus` (default for STAGES), `Stop`/`NoStop`, and the stage index names (PC/IF/ID/EX/MEM/WB).
  - Pipeline registers decode stall bits through these, so they must be shared.
- One sub-module: `sat_counter` (params WIDTH, MAX; inputs inc, clr; outputs count, at_max).
  - Used twice: for `stall_cycles` and for `run_len`.
- Stall merge and the flush FSM stay inline.

## Test plan
- Reset: hold `rst` = 0 with random inputs → all outputs 0. Release and idle 5 cycles → `stall` = 000000, `flush` = 0.
- Single source: `stall_req` = 3'b001 (ID) → `stall` = 000111 in the same cycle. Then 3'b010 (EX) → 001111.
- Merge: `stall_req` = 3'b101 → `stall` = 011111. `stall_cycles` = 3 after 3 such cycles.
- Flush, FLUSH_CYCLES = 2:
  - `excp_valid` pulse with `excp_pc` = 0xBFC00380 while `stall_req` = 3'b111.
  - Same cycle: `stall` = 0.
  - Next 2 cycles: `flush` = 1, `new_pc` = 0xBFC00380.
  - A second pulse in the first flush cycle with 0x80000180 → `new_pc` updates and flush extends 2 more cycles.
- Watchdog, MAX_STALL = 4: hold `stall_req` = 3'b001 for 6 cycles → `stall_timeout` rises after cycle 5 and stays 1 after the request drops.
- Saturation and reset: CNT_W = 4, stall 20 cycles → `stall_cycles` = 15. Assert `rst` = 0 mid-flush → `flush` = 0 and counters are 0 without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control constants: stall bus width, stall level names and stage indices.
// Pipeline registers decode their stall bits through these names, so they live here.
package pipe_ctrl_pkg;

    localparam int STAGE_PC  = 0;
    localparam int STAGE_IF  = 1;
    localparam int STAGE_ID  = 2;
    localparam int STAGE_EX  = 3;
    localparam int STAGE_MEM = 4;
    localparam int STAGE_WB  = 5;

    localparam int STALL_BUS = STAGE_WB + 1;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } ctrl_state_t;

    // A request raised at stage req_stage holds that stage and every stage upstream of it.
    function automatic logic stage_covered(input logic [7:0] stage, input logic [7:0] req_stage);
        return (stage <= req_stage);
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat.sv
// Saturating up-counter with synchronous clear; used for the stall-cycle total and the
// consecutive-stall run length.
module sat_counter #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             at_max
);

    assign at_max = (count == MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: merges per-stage stall requests into one stall vector, sequences
// multi-cycle flushes with a redirect PC, and tracks stall statistics plus a watchdog.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int                  STAGES       = STALL_BUS,
    parameter int                  NREQ         = 3,
    parameter logic [NREQ*8-1:0]   REQ_STAGE    = {8'(STAGE_MEM), 8'(STAGE_EX), 8'(STAGE_ID)},
    parameter int                  FLUSH_CYCLES = 1,
    parameter int                  MAX_STALL    = 64,
    parameter int                  CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   stall_req,
    input  logic              excp_valid,
    input  logic [31:0]       excp_pc,
    output logic [STAGES-1:0] stall,
    output logic              flush,
    output logic [31:0]       new_pc,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic              stall_timeout
);

    localparam int               RUN_W   = $clog2(MAX_STALL + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);
    localparam int               FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0]  FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

    ctrl_state_t       state;
    logic [FC_W-1:0]   flush_cnt;
    logic [STAGES-1:0] stall_merged;
    logic              stall_any;
    logic [RUN_W-1:0]  run_len;
    logic              run_at_max;
    logic              cycles_at_max;

    always_comb begin
        stall_merged = {STAGES{NO_STOP}};
        for (int i = 0; i < NREQ; i++) begin
            for (int k = STAGE_PC; k < STAGES; k++) begin
                if (stall_req[i] == STOP && stage_covered(8'(k), REQ_STAGE[8*i +: 8])) begin
                    stall_merged[k] = STOP;
                end
            end
        end
    end

    // Flushing wins over stalling, including the cycle the event arrives; reset also masks it.
    assign stall     = (!rst || state == ST_FLUSH || excp_valid) ? '0 : stall_merged;
    assign stall_any = |stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_RUN;
            flush     <= 1'b0;
            new_pc    <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (excp_valid) begin
                        state     <= ST_FLUSH;
                        flush     <= 1'b1;
                        new_pc    <= excp_pc;
                        flush_cnt <= FC_LOAD;
                    end
                end
                ST_FLUSH: begin
                    // A new event mid-flush restarts the window and the latest target wins.
                    if (excp_valid) begin
                        new_pc    <= excp_pc;
                        flush_cnt <= FC_LOAD;
                    end else if (flush_cnt == '0) begin
                        state <= ST_RUN;
                        flush <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_RUN;
                    flush <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH (CNT_W),
        .MAX   ({CNT_W{1'b1}})
    ) u_stall_cycles (
        .clk    (clk),
        .rst    (rst),
        .inc    (stall_any && !cycles_at_max),
        .clr    (1'b0),
        .count  (stall_cycles),
        .at_max (cycles_at_max)
    );

    sat_counter #(
        .WIDTH (RUN_W),
        .MAX   (RUN_MAX)
    ) u_run_len (
        .clk    (clk),
        .rst    (rst),
        .inc    (stall_any),
        .clr    (!stall_any),
        .count  (run_len),
        .at_max (run_at_max)
    );

    // The watchdog trips on the first stalled cycle beyond the limit and only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_timeout <= 1'b0;
        end else if (stall_any && run_at_max) begin
            stall_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed test-plan steps plus a random phase, all
// compared against a cycle-level behavioural model of the stall/flush/watchdog rules.
module tb_pipe_ctrl;

    localparam int STAGES       = 6;
    localparam int NREQ         = 3;
    localparam int FLUSH_CYCLES = 2;
    localparam int MAX_STALL    = 4;
    localparam int CNT_W        = 4;
    localparam int CNT_SAT      = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   stall_req;
    logic              excp_valid;
    logic [31:0]       excp_pc;
    logic [STAGES-1:0] stall;
    logic              flush;
    logic [31:0]       new_pc;
    logic [CNT_W-1:0]  stall_cycles;
    logic              stall_timeout;

    int tests = 0;
    int fails = 0;

    int          req_stage [NREQ] = '{2, 3, 4};
    int          m_flush_left;
    int          m_cycles;
    int          m_run;
    logic        m_timeout;
    logic [31:0] m_pc;

    pipe_ctrl #(
        .STAGES       (STAGES),
        .NREQ         (NREQ),
        .REQ_STAGE    ({8'd4, 8'd3, 8'd2}),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .MAX_STALL    (MAX_STALL),
        .CNT_W        (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_req     (stall_req),
        .excp_valid    (excp_valid),
        .excp_pc       (excp_pc),
        .stall         (stall),
        .flush         (flush),
        .new_pc        (new_pc),
        .stall_cycles  (stall_cycles),
        .stall_timeout (stall_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [STAGES-1:0] exp_stall();
        int mask;
        mask = 0;
        if (!rst || m_flush_left > 0 || excp_valid) return '0;
        for (int i = 0; i < NREQ; i++) begin
            if (stall_req[i]) mask = mask | ((1 << (req_stage[i] + 1)) - 1);
        end
        return STAGES'(mask);
    endfunction

    task automatic modelReset();
        m_flush_left = 0;
        m_cycles     = 0;
        m_run        = 0;
        m_timeout    = 1'b0;
        m_pc         = '0;
    endtask

    task automatic modelStep();
        logic [STAGES-1:0] es;
        es = exp_stall();
        if (es != '0) begin
            if (m_run == MAX_STALL) m_timeout = 1'b1;
            m_cycles = (m_cycles < CNT_SAT) ? m_cycles + 1 : CNT_SAT;
            m_run    = (m_run < MAX_STALL) ? m_run + 1 : MAX_STALL;
        end else begin
            m_run = 0;
        end
        if (excp_valid) begin
            m_flush_left = FLUSH_CYCLES;
            m_pc         = excp_pc;
        end else if (m_flush_left > 0) begin
            m_flush_left = m_flush_left - 1;
        end
    endtask

    task automatic check(input string tag, input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("[TB] FAIL %s/%s: got %0h expected %0h", tag, name, got, want);
        end
    endtask

    task automatic checkOutput(input string tag);
        check(tag, "stall", 32'(stall), 32'(exp_stall()));
        check(tag, "flush", 32'(flush), (m_flush_left > 0) ? 32'd1 : 32'd0);
        check(tag, "new_pc", new_pc, m_pc);
        check(tag, "stall_cycles", 32'(stall_cycles), 32'(m_cycles));
        check(tag, "stall_timeout", 32'(stall_timeout), 32'(m_timeout));
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] req, input logic ev, input logic [31:0] pc, input string tag);
        stall_req  = req;
        excp_valid = ev;
        excp_pc    = pc;
        #2;
        checkOutput(tag);
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic doReset();
        rst        = 1'b0;
        stall_req  = NREQ'($urandom);
        excp_valid = 1'($urandom);
        excp_pc    = $urandom;
        #1;
        modelReset();
        checkOutput("reset");
        @(posedge clk);
        #1;
        checkOutput("reset_hold");
        rst = 1'b1;
    endtask

    initial begin
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(3'b000, 1'b0, 32'h0, "idle");

        applyStimulus(3'b001, 1'b0, 32'h0, "single_id");
        applyStimulus(3'b010, 1'b0, 32'h0, "single_ex");

        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(3'b101, 1'b0, 32'h0, "merge");
        check("merge", "stall_cycles_3", 32'(stall_cycles), 32'd3);

        doReset();
        applyStimulus(3'b111, 1'b1, 32'hBFC0_0380, "excp1");
        applyStimulus(3'b111, 1'b1, 32'h8000_0180, "excp2_in_flush");
        applyStimulus(3'b111, 1'b0, 32'h0, "flush_ext1");
        applyStimulus(3'b111, 1'b0, 32'h0, "flush_ext2");
        applyStimulus(3'b111, 1'b0, 32'h0, "after_flush");
        check("flush", "new_pc_latest", new_pc, 32'h8000_0180);

        doReset();
        for (int i = 0; i < 6; i++) applyStimulus(3'b001, 1'b0, 32'h0, "watchdog");
        for (int i = 0; i < 3; i++) applyStimulus(3'b000, 1'b0, 32'h0, "watchdog_drop");
        check("watchdog", "timeout_sticky", 32'(stall_timeout), 32'd1);

        doReset();
        for (int i = 0; i < 300; i++) begin
            applyStimulus(NREQ'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0), $urandom, "random");
        end

        doReset();
        for (int i = 0; i < 20; i++) applyStimulus(3'b001, 1'b0, 32'h0, "saturate");
        check("saturate", "stall_cycles_sat", 32'(stall_cycles), 32'(CNT_SAT));
        applyStimulus(3'b000, 1'b1, 32'h1234_5678, "sat_excp");
        stall_req  = 3'b000;
        excp_valid = 1'b0;
        #2;
        checkOutput("mid_flush");
        rst = 1'b0;
        #1;
        check("async_reset", "flush", 32'(flush), 32'd0);
        check("async_reset", "stall_cycles", 32'(stall_cycles), 32'd0);
        check("async_reset", "stall_timeout", 32'(stall_timeout), 32'd0);
        check("async_reset", "new_pc", new_pc, 32'd0);
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(3'b100, 1'b0, 32'h0, "post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
